// File: rtl/pdm_pkg.sv
// Shared state encoding and default sizing for the PDM capture/playback controller.
// No logic lives here; the controller imports it.
package pdm_pkg;

  localparam int PDM_ADDR_W  = 16;
  localparam int PDM_DISCARD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RECORD,
    ST_PLAY_RD,
    ST_PLAY_WAIT,
    ST_PLAY_OUT
  } pdm_state_e;

endpackage

// File: rtl/pdm_capture_ctrl.sv
// Records PDM amplitude samples into an external buffer and plays them back over valid/ready.
// Playback is 3 cycles per sample; play_data holds while play_ready is low.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int ADDR_W  = PDM_ADDR_W,
  parameter int DISCARD = PDM_DISCARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic [6:0]        amplitude,
  input  logic              amplitude_valid,
  output logic              mic_enable,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [6:0]        ram_wdata,
  input  logic [6:0]        ram_rdata,
  output logic [6:0]        play_data,
  output logic              play_valid,
  input  logic              play_ready,
  output logic [ADDR_W:0]   rec_length,
  output logic              busy,
  output logic              full
);

  localparam int DW = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

  pdm_state_e        state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DW-1:0]     disc_cnt, disc_nx;
  logic [ADDR_W:0]   len_q, len_nx;
  logic              full_q, full_nx;
  logic [6:0]        pdata_q, pdata_nx;
  logic              wr_en;

  // A sample arriving together with stop is deliberately dropped.
  assign wr_en = (state == ST_RECORD) && amplitude_valid && !stop;

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    disc_nx  = disc_cnt;
    len_nx   = len_q;
    full_nx  = full_q;
    pdata_nx = pdata_q;
    if (stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rec) begin
            state_nx = ST_ARM;
            full_nx  = 1'b0;
            len_nx   = '0;
            addr_nx  = '0;
            disc_nx  = '0;
          end else if (start_play) begin
            state_nx = ST_PLAY_RD;
            addr_nx  = '0;
          end
        end
        ST_ARM: begin
          if (DISCARD == 0) begin
            state_nx = ST_RECORD;
          end else if (amplitude_valid) begin
            if (int'(disc_cnt) + 1 >= DISCARD) begin
              state_nx = ST_RECORD;
              disc_nx  = '0;
            end else begin
              disc_nx = disc_cnt + 1'b1;
            end
          end
        end
        ST_RECORD: begin
          if (amplitude_valid) begin
            len_nx = len_q + 1'b1;
            // Last slot written: stop here rather than wrap over old samples.
            if (addr == '1) begin
              full_nx  = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              addr_nx = addr + 1'b1;
            end
          end
        end
        ST_PLAY_RD: begin
          state_nx = (len_q == '0) ? ST_IDLE : ST_PLAY_WAIT;
        end
        ST_PLAY_WAIT: begin
          pdata_nx = ram_rdata;
          state_nx = ST_PLAY_OUT;
        end
        ST_PLAY_OUT: begin
          if (play_ready) begin
            if ({1'b0, addr} == len_q - 1'b1) begin
              state_nx = ST_IDLE;
            end else begin
              addr_nx  = addr + 1'b1;
              state_nx = ST_PLAY_RD;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      disc_cnt <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      pdata_q  <= '0;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      disc_cnt <= disc_nx;
      len_q    <= len_nx;
      full_q   <= full_nx;
      pdata_q  <= pdata_nx;
    end
  end

  assign mic_enable = (state == ST_ARM) || (state == ST_RECORD);
  assign busy       = (state != ST_IDLE);
  assign play_valid = (state == ST_PLAY_OUT);
  assign ram_we     = wr_en;
  assign ram_addr   = addr;
  assign ram_wdata  = wr_en ? amplitude : 7'd0;
  assign play_data  = pdata_q;
  assign rec_length = len_q;
  assign full       = full_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl: behavioural buffer RAM, write/playback monitors and a
// sample-list reference model of what a recording should leave in the buffer.
module tb_pdm_capture_ctrl;

  localparam int AW    = 4;
  localparam int DISC  = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_rec = 1'b0;
  logic          start_play = 1'b0;
  logic          stop = 1'b0;
  logic [6:0]    amplitude = '0;
  logic          amplitude_valid = 1'b0;
  logic          play_ready = 1'b0;
  logic          mic_enable, ram_we, play_valid, busy, full;
  logic [AW-1:0] ram_addr;
  logic [6:0]    ram_wdata, ram_rdata, play_data;
  logic [AW:0]   rec_length;

  logic [6:0] mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  int pv_cnt  = 0;
  int wa[$], wd[$], pq[$], pt[$], mdl[$];
  logic pv_q = 1'b0, pr_q = 1'b0, last_wr_q = 1'b0;
  logic [6:0] pd_q = '0;

  pdm_capture_ctrl #(.ADDR_W(AW), .DISCARD(DISC)) dut (
    .clk(clk), .rst_n(rst_n), .start_rec(start_rec), .start_play(start_play), .stop(stop),
    .amplitude(amplitude), .amplitude_valid(amplitude_valid), .mic_enable(mic_enable),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .play_data(play_data), .play_valid(play_valid), .play_ready(play_ready),
    .rec_length(rec_length), .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wa.push_back(int'(ram_addr));
        wd.push_back(int'(ram_wdata));
      end
      if (ram_we && !mic_enable) viol++;
      if (play_valid && mic_enable) viol++;
      if (last_wr_q && busy) viol++;
      if (pv_q && !pr_q && (!play_valid || play_data !== pd_q)) viol++;
      if (play_valid) pv_cnt++;
      if (play_valid && play_ready) begin
        pq.push_back(int'(play_data));
        pt.push_back(cyc);
      end
    end
    last_wr_q = rst_n && ram_we && (ram_addr == 4'(DEPTH - 1));
    pv_q = rst_n && play_valid;
    pr_q = play_ready;
    pd_q = play_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive nv amplitude pulses; the model keeps the list of accepted samples and
  // expects the first DISC dropped and at most DEPTH of the rest stored in order.
  task automatic do_record(input string tag, input int nv, input bit stop_last,
                           input bit fixed, input int base);
    int stream[$];
    int k, a, gap;
    wa.delete();
    wd.delete();
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 0; i < nv; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      a = fixed ? base + i : int'($urandom_range(0, 127));
      amplitude = 7'(a);
      amplitude_valid = 1'b1;
      if (stop_last && i == nv - 1) stop = 1'b1;
      else stream.push_back(a);
      step();
      amplitude_valid = 1'b0;
      stop = 1'b0;
    end
    if (!stop_last || nv == 0) begin
      stop = 1'b1; step(); stop = 1'b0;
    end
    step(); step();
    k = stream.size() - DISC;
    if (k < 0) k = 0;
    if (k > DEPTH) k = DEPTH;
    mdl.delete();
    for (int i = 0; i < k; i++) mdl.push_back(stream[DISC + i]);
    chk({tag, "_nwr"}, wa.size(), k);
    for (int i = 0; i < k && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], i);
      chk({tag, "_data"}, wd[i], mdl[i]);
    end
    chk({tag, "_len"}, rec_length, k);
    chk({tag, "_full"}, full, (k == DEPTH) ? 1 : 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mic"}, mic_enable, 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall second sample for 10 cycles.
  task automatic do_play(input string tag, input int mode);
    int budget, stall, hold;
    budget = 0; stall = 0; hold = 0;
    pq.delete();
    pt.delete();
    start_play = 1'b1; step(); start_play = 1'b0;
    while (busy && budget < 300) begin
      if (mode == 0) play_ready = 1'b1;
      else if (mode == 1) play_ready = 1'($urandom_range(0, 1));
      else if (pq.size() == 1 && play_valid && stall < 10) begin
        play_ready = 1'b0;
        stall++;
        if (play_data === 7'(mdl[1])) hold++;
      end else play_ready = 1'b1;
      step();
      budget++;
    end
    play_ready = 1'b0;
    chk({tag, "_done"}, busy, 0);
    chk({tag, "_count"}, pq.size(), mdl.size());
    for (int i = 0; i < pq.size() && i < mdl.size(); i++)
      chk({tag, "_data"}, pq[i], mdl[i]);
    if (mode == 0)
      for (int i = 1; i < pt.size(); i++) chk({tag, "_spacing"}, pt[i] - pt[i-1], 3);
    if (mode == 2) chk({tag, "_hold"}, hold, 10);
  endtask

  initial begin
    int nv, n, save;
    bit sl;
    #1;
    chk("rst_mic", mic_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_pvalid", play_valid, 0);
    chk("rst_len", rec_length, 0);
    chk("rst_full", full, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_pdata", play_data, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    do_record("basic_rec", 5, 1'b0, 1'b1, 10);
    do_play("basic_play", 0);
    do_play("stall_play", 2);

    do_record("full_rec", 22, 1'b0, 1'b0, 0);
    do_play("full_play", 0);

    for (int r = 0; r < 4; r++) begin
      nv = int'($urandom_range(0, 22));
      sl = 1'($urandom_range(0, 1));
      do_record("rnd_rec", nv, sl, 1'b0, 0);
      do_play("rnd_play", 1);
    end

    // Simultaneous starts, start_play while recording, then an empty recording.
    wa.delete();
    wd.delete();
    start_rec = 1'b1; start_play = 1'b1; step(); start_rec = 1'b0; start_play = 1'b0;
    chk("both_start_mic", mic_enable, 1);
    chk("both_start_pvalid", play_valid, 0);
    for (int i = 0; i < DISC; i++) begin
      amplitude = 7'(20 + i); amplitude_valid = 1'b1; step(); amplitude_valid = 1'b0; step();
    end
    start_play = 1'b1; step(); start_play = 1'b0;
    chk("play_in_rec_mic", mic_enable, 1);
    amplitude = 7'd77; amplitude_valid = 1'b1; step(); amplitude_valid = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("ignore_len", rec_length, 1);
    chk("ignore_data", (wd.size() > 0) ? wd[0] : -1, 77);
    start_rec = 1'b1; step(); start_rec = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("empty_len", rec_length, 0);
    save = pv_cnt;
    start_play = 1'b1; step(); start_play = 1'b0;
    step();
    chk("empty_play_idle", busy, 0);
    chk("empty_play_pvalid", pv_cnt - save, 0);

    // Asynchronous reset at buffer address 5 with a sample arriving.
    wa.delete();
    wd.delete();
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 0; i < DISC + 5; i++) begin
      amplitude = 7'(40 + i); amplitude_valid = 1'b1; step(); amplitude_valid = 1'b0; step();
    end
    chk("pre_rst_writes", wa.size(), 5);
    amplitude = 7'd99;
    amplitude_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mic", mic_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_we", ram_we, 0);
    chk("arst_wdata", ram_wdata, 0);
    chk("arst_addr", ram_addr, 0);
    chk("arst_len", rec_length, 0);
    chk("arst_pvalid", play_valid, 0);
    chk("arst_pdata", play_data, 0);
    amplitude_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n = wa.size();
    amplitude_valid = 1'b1; step(); amplitude_valid = 1'b0;
    step(); step();
    chk("post_rst_no_we", wa.size(), n);
    chk("post_rst_len", rec_length, 0);
    chk("post_rst_busy", busy, 0);

    chk("protocol", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
